// File: rtl/fab_clk_reset_ctrl_pkg.sv
// fab_clk_reset_ctrl_pkg
// Shared definitions for the fabric clock/reset controller: state encoding,
// counter widths and the lock-loss filter depth. The filter depth is used
// only when the controller is built with FAB_LOCK_FILTER_EN defined.

package fab_clk_reset_ctrl_pkg;

    // Width of the stabilisation and tick counters. A 16-bit counter holds
    // every terminal value (STABLE_CYCLES-1, TICK_DIV-1) for the parameter
    // range 2..65535, so neither counter can wrap early.
    localparam int CNT_W = 16;

    // Number of consecutive lock-low cycles in RUN that the optional glitch
    // filter treats as a real loss of lock.
    localparam int FILTER_DEPTH = 4;

    // Width of the glitch-filter counter. Three bits hold 0..FILTER_DEPTH-1.
    localparam int FILT_W = 3;

    // Sequencer states. Encoding 3 is never entered on purpose. If it ever
    // appears (for example after an upset), the next-state logic sends it
    // back to WAIT_LOCK.
    typedef enum logic [1:0] {
        ST_WAIT_LOCK = 2'd0,
        ST_STABILIZE = 2'd1,
        ST_RUN       = 2'd2,
        ST_ILLEGAL   = 2'd3
    } state_e;

    // Terminal value of a CNT_W-bit counter that divides by 'n'.
    function automatic logic [CNT_W-1:0] cnt_last(input int n);
        return CNT_W'(n - 1);
    endfunction

endpackage : fab_clk_reset_ctrl_pkg

// File: rtl/fab_clk_reset_ctrl_lock_sync.sv
// fab_clk_reset_ctrl_lock_sync
// Two-flop synchroniser that brings the CCC lock indication into the FAB_CLK
// domain. Both flops reset to 0, so after reset the controller always sees
// "not locked" until the input has been sampled high twice.

module fab_clk_reset_ctrl_lock_sync
    import fab_clk_reset_ctrl_pkg::*;
(
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_async,
    output logic o_sync
);

    logic r_meta;
    logic r_sync;

    // Capture the asynchronous input, then re-register it to let the first
    // stage settle before anything downstream uses it.
    always_ff @(posedge i_clk) begin
        // NOTE: state registers use non-blocking assignments, so both flops
        // update from their pre-edge values and the chain really is two
        // stages deep. Blocking assignments would collapse it to one stage.
        if (!i_rst_n) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
        end
    end

    assign o_sync = r_sync;

endmodule : fab_clk_reset_ctrl_lock_sync

// File: rtl/fab_clk_reset_ctrl.sv
// fab_clk_reset_ctrl
// Holds the H-bridge fabric logic in reset until the MSS CCC has reported
// lock for STABLE_CYCLES consecutive FAB_CLK cycles. It then releases
// FAB_RESET_N and produces a TICK clock-enable every TICK_DIV cycles. If
// lock is lost while running, the block returns to WAIT_LOCK, reasserts
// reset and sets the sticky LOCK_LOST flag.
//
// Build option: define FAB_LOCK_FILTER_EN to add a glitch filter. With it,
// lock must be low for FILTER_DEPTH consecutive cycles in RUN before it
// counts as lost. Without it, a single low cycle in RUN counts as a loss.

module fab_clk_reset_ctrl
    import fab_clk_reset_ctrl_pkg::*;
#(
    parameter int STABLE_CYCLES = 256,
    parameter int TICK_DIV      = 20,
    parameter int USE_LOCK      = 1
) (
    input  logic       FAB_CLK,
    input  logic       M2F_RESET_N,
    input  logic       FAB_LOCK,
    output logic       FAB_RESET_N,
    output logic       TICK,
    output logic [1:0] STATE,
    output logic       LOCK_LOST
);

    localparam logic [CNT_W-1:0] STAB_LAST = cnt_last(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] TICK_LAST = cnt_last(TICK_DIV);

    // ------------------------------------------------------------------
    // Lock synchroniser
    // ------------------------------------------------------------------
    // When the lock input is not used, a constant 1 is fed through the same
    // synchroniser. Release latency after reset is then identical to the
    // case where lock is already high as reset deasserts.
    logic w_lock_in;
    logic w_lock_s;

    assign w_lock_in = (USE_LOCK != 0) ? FAB_LOCK : 1'b1;

    fab_clk_reset_ctrl_lock_sync u_lock_sync (
        .i_clk   (FAB_CLK),
        .i_rst_n (M2F_RESET_N),
        .i_async (w_lock_in),
        .o_sync  (w_lock_s)
    );

    // ------------------------------------------------------------------
    // Registers and next-state wires
    // ------------------------------------------------------------------
    state_e           r_state;
    state_e           w_state_next;
    logic [CNT_W-1:0] r_stab_cnt;
    logic [CNT_W-1:0] r_tick_cnt;
    logic             r_lock_lost;
    logic             w_lock_loss;

    // ------------------------------------------------------------------
    // Lock-loss detection while in RUN
    // ------------------------------------------------------------------
`ifdef FAB_LOCK_FILTER_EN
    localparam logic [FILT_W-1:0] FILT_LAST = FILT_W'(FILTER_DEPTH - 1);

    logic [FILT_W-1:0] r_filt_cnt;

    // Count consecutive lock-low cycles spent in RUN. Any high sample, or
    // leaving RUN, restarts the count.
    always_ff @(posedge FAB_CLK) begin
        if (!M2F_RESET_N) begin
            r_filt_cnt <= '0;
        end else if ((r_state != ST_RUN) || w_lock_s) begin
            r_filt_cnt <= '0;
        end else if (r_filt_cnt != FILT_LAST) begin
            r_filt_cnt <= r_filt_cnt + 1'b1;
        end
    end

    // Lock is lost on the FILTER_DEPTH-th consecutive low cycle.
    assign w_lock_loss = (r_state == ST_RUN) && !w_lock_s && (r_filt_cnt == FILT_LAST);
`else
    // Without the filter, any low cycle in RUN counts as a loss of lock.
    assign w_lock_loss = (r_state == ST_RUN) && !w_lock_s;
`endif

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    // Hold the current sequencer state. Reset is synchronous and overrides
    // every transition.
    always_ff @(posedge FAB_CLK) begin
        if (!M2F_RESET_N) begin
            r_state <= ST_WAIT_LOCK;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    // Sequence WAIT_LOCK -> STABILIZE -> RUN. Any drop of lock before RUN,
    // or a lock loss in RUN, sends the FSM back to WAIT_LOCK.
    always_comb begin
        // NOTE: assigning a default before the case gives every path a
        // value, so no latch can be inferred for w_state_next.
        w_state_next = r_state;
        case (r_state)
            ST_WAIT_LOCK: begin
                if (w_lock_s) begin
                    w_state_next = ST_STABILIZE;
                end
            end
            ST_STABILIZE: begin
                if (!w_lock_s) begin
                    w_state_next = ST_WAIT_LOCK;
                end else if (r_stab_cnt == STAB_LAST) begin
                    w_state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (w_lock_loss) begin
                    w_state_next = ST_WAIT_LOCK;
                end
            end
            default: begin
                w_state_next = ST_WAIT_LOCK;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Stabilisation counter
    // ------------------------------------------------------------------
    // Count locked cycles only while staying in STABILIZE. Every other case
    // clears the counter, so each entry to STABILIZE starts from 0.
    always_ff @(posedge FAB_CLK) begin
        if (!M2F_RESET_N) begin
            r_stab_cnt <= '0;
        end else if ((r_state == ST_STABILIZE) && (w_state_next == ST_STABILIZE)) begin
            r_stab_cnt <= r_stab_cnt + 1'b1;
        end else begin
            r_stab_cnt <= '0;
        end
    end

    // ------------------------------------------------------------------
    // Tick divider
    // ------------------------------------------------------------------
    // Advance the divider only while RUN continues. It is already 0 on the
    // first RUN cycle, so the first TICK falls on RUN cycle TICK_DIV.
    always_ff @(posedge FAB_CLK) begin
        if (!M2F_RESET_N) begin
            r_tick_cnt <= '0;
        end else if ((r_state == ST_RUN) && (w_state_next == ST_RUN)) begin
            if (r_tick_cnt == TICK_LAST) begin
                r_tick_cnt <= '0;
            end else begin
                r_tick_cnt <= r_tick_cnt + 1'b1;
            end
        end else begin
            r_tick_cnt <= '0;
        end
    end

    // ------------------------------------------------------------------
    // Sticky lock-lost flag
    // ------------------------------------------------------------------
    // Record any loss of lock in RUN. Only reset clears this flag; entering
    // RUN again leaves it set.
    always_ff @(posedge FAB_CLK) begin
        if (!M2F_RESET_N) begin
            r_lock_lost <= 1'b0;
        end else if (w_lock_loss) begin
            r_lock_lost <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // FSM: output decode
    // ------------------------------------------------------------------
    // All outputs are decoded from registers only. FAB_RESET_N and TICK both
    // depend on r_state == RUN, so TICK drops in the same cycle that
    // FAB_RESET_N falls.
    always_comb begin
        FAB_RESET_N = (r_state == ST_RUN);
        TICK        = (r_state == ST_RUN) && (r_tick_cnt == TICK_LAST);
        STATE       = r_state;
        LOCK_LOST   = r_lock_lost;
    end

endmodule : fab_clk_reset_ctrl

// File: tb/tb_fab_clk_reset_ctrl.sv
// tb_fab_clk_reset_ctrl
// Self-checking bench for fab_clk_reset_ctrl with STABLE_CYCLES=16 and
// TICK_DIV=4. The bench expects the filtered lock-loss behaviour when it is
// compiled with FAB_LOCK_FILTER_EN defined.
//
// The reference model works on streaks. It counts consecutive synchronised
// lock-high and lock-low cycles. A streak of more than STABLE_CYCLES highs
// enters RUN, and a streak of LOSS lows leaves it. In RUN, TICK is high when
// the number of cycles spent in RUN is a multiple of TICK_DIV.

module tb_fab_clk_reset_ctrl;

    localparam int S   = 16;
    localparam int DIV = 4;
`ifdef FAB_LOCK_FILTER_EN
    localparam int LOSS = 4;
`else
    localparam int LOSS = 1;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       lock = 1'b0;
    logic       rst_nl_n = 1'b0;

    logic       o_rstn;
    logic       o_tick;
    logic [1:0] o_state;
    logic       o_lost;

    logic       nl_rstn;
    logic       nl_tick;
    logic [1:0] nl_state;
    logic       nl_lost;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    fab_clk_reset_ctrl #(.STABLE_CYCLES(S), .TICK_DIV(DIV), .USE_LOCK(1)) dut (
        .FAB_CLK     (clk),
        .M2F_RESET_N (rst_n),
        .FAB_LOCK    (lock),
        .FAB_RESET_N (o_rstn),
        .TICK        (o_tick),
        .STATE       (o_state),
        .LOCK_LOST   (o_lost)
    );

    // Second instance: lock input ignored and tied low.
    fab_clk_reset_ctrl #(.STABLE_CYCLES(S), .TICK_DIV(DIV), .USE_LOCK(0)) dut_nl (
        .FAB_CLK     (clk),
        .M2F_RESET_N (rst_nl_n),
        .FAB_LOCK    (1'b0),
        .FAB_RESET_N (nl_rstn),
        .TICK        (nl_tick),
        .STATE       (nl_state),
        .LOCK_LOST   (nl_lost)
    );

    // ---------------- reference model ----------------
    logic m_s1, m_s2;
    int   m_ones, m_zeros, m_run_cycles;
    logic m_in_run, m_lost;

    task automatic model_step();
        logic ls;
        if (!rst_n) begin
            m_s1 = 1'b0; m_s2 = 1'b0;
            m_ones = 0; m_zeros = 0; m_run_cycles = 0;
            m_in_run = 1'b0; m_lost = 1'b0;
        end else begin
            ls   = m_s2;
            m_s2 = m_s1;
            m_s1 = lock;
            if (ls) begin
                m_ones++;
                m_zeros = 0;
            end else begin
                m_zeros++;
                m_ones = 0;
            end
            if (m_in_run) begin
                if (m_zeros >= LOSS) begin
                    m_in_run = 1'b0;
                    m_lost = 1'b1;
                    m_run_cycles = 0;
                end else begin
                    m_run_cycles++;
                end
            end else if (m_ones >= S + 1) begin
                m_in_run = 1'b1;
                m_run_cycles = 1;
            end
        end
    endtask

    function automatic logic [7:0] model_exp();
        logic [1:0] st;
        logic       tk;
        st = m_in_run ? 2'd2 : ((m_ones > 0) ? 2'd1 : 2'd0);
        tk = m_in_run && ((m_run_cycles % DIV) == 0);
        return {3'b000, st, m_in_run, tk, m_lost};
    endfunction

    function automatic logic [7:0] obs();
        return {3'b000, o_state, o_rstn, o_tick, o_lost};
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got {state,rstn,tick,lost}=%b, expected %b at t=%0t",
                     name, act[4:0], exp[4:0], $time);
        end
    endtask

    // Apply one cycle of inputs, step the model on the edge, and compare
    // the DUT against the model on the following falling edge.
    task automatic cyc(input logic r, input logic l);
        rst_n = r;
        lock  = l;
        @(posedge clk);
        model_step();
        @(negedge clk);
        check("model", obs(), model_exp());
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic       rst;
        logic       lk;
        int         n;
        logic [1:0] st;
        logic       rstn;
        logic       tick;
        logic       lost;
    } vec_t;

    localparam int NV = 27;
    vec_t tbl[NV];

    function automatic vec_t mk(input logic r, input logic l, input int n,
                                input logic [1:0] st, input logic rn,
                                input logic tk, input logic ls);
        vec_t v;
        v.rst = r; v.lk = l; v.n = n; v.st = st; v.rstn = rn; v.tick = tk; v.lost = ls;
        return v;
    endfunction

    initial begin
        // Reset state, then lock rises 5 cycles after reset release.
        tbl[0]  = mk(0, 0, 3,  2'd0, 0, 0, 0);
        tbl[1]  = mk(1, 0, 5,  2'd0, 0, 0, 0);
        tbl[2]  = mk(1, 1, 2,  2'd0, 0, 0, 0);  // first sample edge and sync edge
        tbl[3]  = mk(1, 1, 1,  2'd1, 0, 0, 0);  // edge 2: STABILIZE
        tbl[4]  = mk(1, 1, 15, 2'd1, 0, 0, 0);  // edge 17: still STABILIZE
        tbl[5]  = mk(1, 1, 1,  2'd2, 1, 0, 0);  // edge 18: RUN, reset released
        tbl[6]  = mk(1, 1, 3,  2'd2, 1, 1, 0);  // RUN cycle 4: TICK
        tbl[7]  = mk(1, 1, 1,  2'd2, 1, 0, 0);  // RUN cycle 5
        tbl[8]  = mk(1, 1, 3,  2'd2, 1, 1, 0);  // RUN cycle 8: TICK
        tbl[9]  = mk(1, 0, 2,  2'd2, 1, 0, 0);  // two low cycles, not yet visible
`ifdef FAB_LOCK_FILTER_EN
        tbl[10] = mk(1, 1, 1,  2'd2, 1, 0, 0);  // filtered: stay in RUN
        tbl[11] = mk(1, 1, 1,  2'd2, 1, 1, 0);  // RUN cycle 12: TICK
`else
        tbl[10] = mk(1, 1, 1,  2'd0, 0, 0, 1);  // lock lost
        tbl[11] = mk(1, 1, 1,  2'd0, 0, 0, 1);  // second low sample keeps WAIT_LOCK
`endif
        // One-cycle reset mid-sequence, then a fresh release.
        tbl[12] = mk(0, 1, 1,  2'd0, 0, 0, 0);
        tbl[13] = mk(1, 1, 18, 2'd1, 0, 0, 0);
        tbl[14] = mk(1, 1, 1,  2'd2, 1, 0, 0);  // 18 edges after the first sample
        // Lock glitch at stabilise count 10 restarts the full count.
        tbl[15] = mk(0, 0, 2,  2'd0, 0, 0, 0);
        tbl[16] = mk(1, 1, 2,  2'd0, 0, 0, 0);
        tbl[17] = mk(1, 1, 1,  2'd1, 0, 0, 0);  // count 0
        tbl[18] = mk(1, 1, 8,  2'd1, 0, 0, 0);  // count 8
        tbl[19] = mk(1, 0, 1,  2'd1, 0, 0, 0);  // glitch sampled
        tbl[20] = mk(1, 1, 1,  2'd1, 0, 0, 0);  // count 10
        tbl[21] = mk(1, 1, 1,  2'd0, 0, 0, 0);  // glitch reaches FSM
        tbl[22] = mk(1, 1, 1,  2'd1, 0, 0, 0);  // restart
        tbl[23] = mk(1, 1, 15, 2'd1, 0, 0, 0);
        tbl[24] = mk(1, 1, 1,  2'd2, 1, 0, 0);  // a full 16 cycles later
        tbl[25] = mk(1, 1, 3,  2'd2, 1, 1, 0);
        tbl[26] = mk(0, 1, 1,  2'd0, 0, 0, 0);  // reset from RUN
    end

    // ---------------- test sequence ----------------
    initial begin
        logic lvl;
        int   done;
        int   len;
        logic r;

        @(negedge clk);

        // Directed vectors, checked at the end of each row.
        for (int i = 0; i < NV; i++) begin
            for (int c = 0; c < tbl[i].n; c++) begin
                cyc(tbl[i].rst, tbl[i].lk);
            end
            check($sformatf("vec%0d", i), obs(),
                  {3'b000, tbl[i].st, tbl[i].rstn, tbl[i].tick, tbl[i].lost});
        end

        // Randomised lock waveform with occasional resets, checked against
        // the model on every cycle.
        lvl  = 1'b1;
        done = 0;
        while (done < 2500) begin
            len = lvl ? int'($urandom_range(1, 40)) : int'($urandom_range(1, 6));
            for (int c = 0; c < len; c++) begin
                r = ($urandom_range(0, 199) != 0);
                cyc(r, lvl);
                done++;
            end
            lvl = ~lvl;
        end
        cyc(1'b0, 1'b0);

        // USE_LOCK=0 with the lock input tied low. Edge 1 is the first edge
        // with reset deasserted. FAB_RESET_N must rise S+2 edges after it.
        rst_nl_n = 1'b1;
        for (int k = 1; k <= S + 3; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (k == 1) begin
                check("nolock_edge1", {3'b000, nl_state, nl_rstn, nl_tick, nl_lost}, 8'h00);
            end
            if (k == S + 2) begin
                check("nolock_before", {3'b000, nl_state, nl_rstn, nl_tick, nl_lost},
                      {3'b000, 2'd1, 1'b0, 1'b0, 1'b0});
            end
            if (k == S + 3) begin
                check("nolock_release", {3'b000, nl_state, nl_rstn, nl_tick, nl_lost},
                      {3'b000, 2'd2, 1'b1, 1'b0, 1'b0});
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_fab_clk_reset_ctrl
